// File: rtl/ups_regs_pkg.sv
// Shared constants, response codes and FSM state types for the UPS AXI4-Lite register block.
package ups_regs_pkg;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5550_5301;

  // Byte offsets within the 32-byte register window.
  localparam logic [4:0] OFF_ID       = 5'h00;
  localparam logic [4:0] OFF_CTRL     = 5'h04;
  localparam logic [4:0] OFF_STATUS   = 5'h08;
  localparam logic [4:0] OFF_IRQ_PEND = 5'h0C;
  localparam logic [4:0] OFF_IRQ_EN   = 5'h10;
  localparam logic [4:0] OFF_SCRATCH  = 5'h14;
  localparam logic [4:0] OFF_CYCLES   = 5'h18;
  localparam logic [4:0] OFF_INVALID  = 5'h1C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic [1:0] resp_for(input logic [2:0] idx);
    return ({idx, 2'b00} == OFF_INVALID) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/ups_axil_slave_if.sv
// AXI4-Lite slave front end: independent write/read channel FSMs plus AW/W holding registers.
// Handshake rule: a beat transfers on the rising edge where valid and ready are both high;
// valid, once raised, is held with stable payload until that edge.
import ups_regs_pkg::*;

module ups_axil_slave_if (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  aw_idx,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [2:0]  ar_idx,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] rd_data,
  output logic        wr_en,
  output logic [2:0]  wr_idx,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  output w_state_t    w_state,
  output r_state_t    r_state
);

  w_state_t w_next;
  r_state_t r_next;
  logic     ready_en;
  logic     aw_held, w_held;
  logic     aw_take, w_take, ar_take;
  logic     both_got;

  // Keeps every ready low until the first edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  assign awready  = ready_en && (w_state == W_IDLE) && !aw_held;
  assign wready   = ready_en && (w_state == W_IDLE) && !w_held;
  assign arready  = ready_en && (r_state == R_IDLE);
  assign aw_take  = awvalid && awready;
  assign w_take   = wvalid && wready;
  assign ar_take  = arvalid && arready;
  assign both_got = (aw_held || aw_take) && (w_held || w_take);
  assign bvalid   = (w_state == W_RESP);
  assign rvalid   = (r_state == R_DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    r_next = r_state;
    case (w_state)
      W_IDLE: if (both_got) w_next = W_RESP;
      W_RESP: if (bready)   w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    case (r_state)
      R_IDLE: if (ar_take) r_next = R_DATA;
      R_DATA: if (rready)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      wr_en   <= 1'b0;
      wr_idx  <= '0;
      wr_data <= '0;
      wr_strb <= '0;
      bresp   <= RESP_OKAY;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      // Commit pulse lands in the first W_RESP cycle, alongside bvalid.
      wr_en <= (w_state == W_IDLE) && both_got;
      if (aw_take) begin
        aw_held <= 1'b1;
        wr_idx  <= aw_idx;
        bresp   <= resp_for(aw_idx);
      end
      if (w_take) begin
        w_held  <= 1'b1;
        wr_data <= wdata;
        wr_strb <= wstrb;
      end
      if ((w_state == W_RESP) && bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (ar_take) begin
        rdata <= rd_data;
        rresp <= resp_for(ar_idx);
      end
    end
  end

endmodule

// File: rtl/ups_axil_regs.sv
// UPS control/status register bank behind an AXI4-Lite slave, with event-driven interrupt.
import ups_regs_pkg::*;

module ups_axil_regs #(
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT,
  parameter int          N_EVT    = 8
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic [31:0]      ca4l_awaddr,
  input  logic [2:0]       ca4l_awprot,
  input  logic             ca4l_awvalid,
  output logic             ca4l_awready,
  input  logic [31:0]      ca4l_wdata,
  input  logic [3:0]       ca4l_wstrb,
  input  logic             ca4l_wvalid,
  output logic             ca4l_wready,
  output logic [1:0]       ca4l_bresp,
  output logic             ca4l_bvalid,
  input  logic             ca4l_bready,
  input  logic [31:0]      ca4l_araddr,
  input  logic [2:0]       ca4l_arprot,
  input  logic             ca4l_arvalid,
  output logic             ca4l_arready,
  output logic [31:0]      ca4l_rdata,
  output logic [1:0]       ca4l_rresp,
  output logic             ca4l_rvalid,
  input  logic             ca4l_rready,
  output logic [31:0]      ctrl_out,
  input  logic [31:0]      status_in,
  input  logic [N_EVT-1:0] event_in,
  output logic             irq
);

  logic [31:0]      ctrl, scratch, status_q, cycles;
  logic [N_EVT-1:0] irq_pend, irq_en, pend_clr;
  logic [31:0]      rd_data, mask, clr_word, pend_ext, en_ext;
  logic             wr_en;
  logic [2:0]       wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;
  w_state_t         w_state;
  r_state_t         r_state;
  logic             unused_bits;

  assign unused_bits = ^{ca4l_awaddr[31:5], ca4l_awaddr[1:0], ca4l_araddr[31:5],
                         ca4l_araddr[1:0], ca4l_awprot, ca4l_arprot,
                         w_state == W_RESP, r_state == R_DATA};

  ups_axil_slave_if u_if (
    .clk     (fclk),
    .rst     (rst),
    .aw_idx  (ca4l_awaddr[4:2]),
    .awvalid (ca4l_awvalid),
    .awready (ca4l_awready),
    .wdata   (ca4l_wdata),
    .wstrb   (ca4l_wstrb),
    .wvalid  (ca4l_wvalid),
    .wready  (ca4l_wready),
    .bresp   (ca4l_bresp),
    .bvalid  (ca4l_bvalid),
    .bready  (ca4l_bready),
    .ar_idx  (ca4l_araddr[4:2]),
    .arvalid (ca4l_arvalid),
    .arready (ca4l_arready),
    .rdata   (ca4l_rdata),
    .rresp   (ca4l_rresp),
    .rvalid  (ca4l_rvalid),
    .rready  (ca4l_rready),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .w_state (w_state),
    .r_state (r_state)
  );

  assign ctrl_out = ctrl;
  assign mask     = strb_mask(wr_strb);
  assign clr_word = wr_data & mask;

  always_comb begin
    pend_ext = '0;
    en_ext   = '0;
    pend_ext[N_EVT-1:0] = irq_pend;
    en_ext[N_EVT-1:0]   = irq_en;
    pend_clr = '0;
    if (wr_en && ({wr_idx, 2'b00} == OFF_IRQ_PEND)) pend_clr = clr_word[N_EVT-1:0];
  end

  always_comb begin
    rd_data = '0;
    case ({ca4l_araddr[4:2], 2'b00})
      OFF_ID:       rd_data = ID_VALUE;
      OFF_CTRL:     rd_data = ctrl;
      OFF_STATUS:   rd_data = status_q;
      OFF_IRQ_PEND: rd_data = pend_ext;
      OFF_IRQ_EN:   rd_data = en_ext;
      OFF_SCRATCH:  rd_data = scratch;
      OFF_CYCLES:   rd_data = cycles;
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      ctrl     <= '0;
      scratch  <= '0;
      status_q <= '0;
      cycles   <= '0;
      irq_pend <= '0;
      irq_en   <= '0;
      irq      <= 1'b0;
    end else begin
      status_q <= status_in;
      cycles   <= cycles + 32'd1;
      // A new event wins over a same-cycle W1C clear.
      irq_pend <= (irq_pend & ~pend_clr) | event_in;
      irq      <= |(irq_pend & irq_en);
      if (wr_en) begin
        case ({wr_idx, 2'b00})
          OFF_CTRL:    ctrl    <= (ctrl & ~mask) | (wr_data & mask);
          OFF_IRQ_EN:  irq_en  <= (irq_en & ~mask[N_EVT-1:0]) | (wr_data[N_EVT-1:0] & mask[N_EVT-1:0]);
          OFF_SCRATCH: scratch <= (scratch & ~mask) | (wr_data & mask);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ups_axil_regs.sv
// Randomized self-checking bench for ups_axil_regs against a register-map reference model.
`timescale 1ns/1ps
module tb_ups_axil_regs;
  import ups_regs_pkg::*;

  localparam int          N_EVT  = 8;
  localparam logic [31:0] ID_VAL = 32'h5550_5301;

  // clock / reset
  logic fclk = 1'b0;
  logic rst  = 1'b1;
  always #5 fclk = ~fclk;

  logic [31:0] ca4l_awaddr, ca4l_wdata, ca4l_araddr, ca4l_rdata, ctrl_out, status_in;
  logic [2:0]  ca4l_awprot, ca4l_arprot;
  logic [3:0]  ca4l_wstrb;
  logic [1:0]  ca4l_bresp, ca4l_rresp;
  logic        ca4l_awvalid, ca4l_awready, ca4l_wvalid, ca4l_wready, ca4l_bvalid, ca4l_bready;
  logic        ca4l_arvalid, ca4l_arready, ca4l_rvalid, ca4l_rready, irq;
  logic [N_EVT-1:0] event_in;

  ups_axil_regs #(.ID_VALUE(ID_VAL), .N_EVT(N_EVT)) dut (
    .fclk(fclk), .rst(rst),
    .ca4l_awaddr(ca4l_awaddr), .ca4l_awprot(ca4l_awprot), .ca4l_awvalid(ca4l_awvalid),
    .ca4l_awready(ca4l_awready), .ca4l_wdata(ca4l_wdata), .ca4l_wstrb(ca4l_wstrb),
    .ca4l_wvalid(ca4l_wvalid), .ca4l_wready(ca4l_wready), .ca4l_bresp(ca4l_bresp),
    .ca4l_bvalid(ca4l_bvalid), .ca4l_bready(ca4l_bready), .ca4l_araddr(ca4l_araddr),
    .ca4l_arprot(ca4l_arprot), .ca4l_arvalid(ca4l_arvalid), .ca4l_arready(ca4l_arready),
    .ca4l_rdata(ca4l_rdata), .ca4l_rresp(ca4l_rresp), .ca4l_rvalid(ca4l_rvalid),
    .ca4l_rready(ca4l_rready), .ctrl_out(ctrl_out), .status_in(status_in),
    .event_in(event_in), .irq(irq)
  );

  // elapsed cycles since reset release: what the CYCLES register should hold
  logic [31:0] tb_cyc;
  always @(posedge fclk or posedge rst) begin
    if (rst) tb_cyc <= '0;
    else     tb_cyc <= tb_cyc + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // reference model of the register map
  logic [31:0]      m_ctrl, m_scratch, m_status;
  logic [N_EVT-1:0] m_en, m_pend;
  logic [31:0]      exp_q[$];

  task automatic model_reset();
    m_ctrl = '0; m_scratch = '0; m_status = '0; m_en = '0; m_pend = '0;
  endtask

  function automatic logic [31:0] model_read(input int idx, input logic [31:0] cyc);
    case (idx)
      0: return ID_VAL;
      1: return m_ctrl;
      2: return m_status;
      3: return 32'(m_pend);
      4: return 32'(m_en);
      5: return m_scratch;
      6: return cyc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [1:0] model_resp(input int idx);
    return (idx == 7) ? 2'b10 : 2'b00;
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] en_w;
    en_w = 32'(m_en);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        if (idx == 1) m_ctrl[8*b +: 8]    = d[8*b +: 8];
        if (idx == 5) m_scratch[8*b +: 8] = d[8*b +: 8];
        if (idx == 4) en_w[8*b +: 8]      = d[8*b +: 8];
      end
    end
    if (idx == 4) m_en = en_w[N_EVT-1:0];
    if (idx == 3)
      for (int i = 0; i < N_EVT; i++)
        if (s[i/8] && d[i]) m_pend[i] = 1'b0;
  endtask

  // driver tasks
  task automatic tick();
    @(posedge fclk);
    @(negedge fclk);
  endtask

  function automatic logic [31:0] mk_addr(input int idx);
    return {27'($urandom), 3'(idx), 2'($urandom_range(0, 3))};
  endfunction

  task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input logic [N_EVT-1:0] evt);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int t = 0, wait_b = 0;
    ca4l_awaddr = mk_addr(idx);
    ca4l_awprot = 3'($urandom_range(0, 7));
    ca4l_wdata  = data;
    ca4l_wstrb  = strb;
    while (!(aw_done && w_done) && t < 64) begin
      if (!aw_done && t >= aw_dly) ca4l_awvalid = 1'b1;
      if (!w_done && t >= w_dly)   ca4l_wvalid  = 1'b1;
      if (aw_done && !w_done) check("awready_while_held", ca4l_awready, 0);
      if (w_done && !aw_done) check("wready_while_held", ca4l_wready, 0);
      hs_aw = ca4l_awvalid && ca4l_awready;
      hs_w  = ca4l_wvalid && ca4l_wready;
      tick();
      if (hs_aw) begin ca4l_awvalid = 1'b0; aw_done = 1; end
      if (hs_w)  begin ca4l_wvalid  = 1'b0; w_done  = 1; end
      t++;
    end
    check("aw_w_accepted", {31'b0, aw_done && w_done}, 1);
    while (!ca4l_bvalid && wait_b < 64) begin tick(); wait_b++; end
    check("bvalid_latency", wait_b, 0);
    event_in = evt;
    for (int i = 0; i < b_dly; i++) begin
      check("bvalid_hold", ca4l_bvalid, 1);
      tick();
      event_in = '0;
    end
    check("bresp", ca4l_bresp, model_resp(idx));
    ca4l_bready = 1'b1;
    tick();
    ca4l_bready = 1'b0;
    event_in    = '0;
    check("bvalid_drop", ca4l_bvalid, 0);
    model_write(idx, data, strb);
    m_pend = m_pend | evt;
  endtask

  task automatic axi_read(input int idx, input int ar_dly, input int r_dly);
    int t = 0;
    repeat (ar_dly) tick();
    ca4l_araddr  = mk_addr(idx);
    ca4l_arprot  = 3'($urandom_range(0, 7));
    ca4l_arvalid = 1'b1;
    while (!ca4l_arready && t < 64) begin tick(); t++; end
    check("arready_seen", {31'b0, ca4l_arready}, 1);
    // handshake occurs on the coming edge; the model value now is what must be captured
    exp_q.push_back(model_read(idx, tb_cyc));
    tick();
    ca4l_arvalid = 1'b0;
    check("rvalid_latency", ca4l_rvalid, 1);
    check("rresp", ca4l_rresp, model_resp(idx));
    check("rdata", ca4l_rdata, exp_q[0]);
    for (int i = 0; i < r_dly; i++) begin
      tick();
      check("rvalid_hold", ca4l_rvalid, 1);
      check("rdata_stable", ca4l_rdata, exp_q[0]);
    end
    ca4l_rready = 1'b1;
    tick();
    ca4l_rready = 1'b0;
    check("rvalid_drop", ca4l_rvalid, 0);
    void'(exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ca4l_awaddr = '0; ca4l_awprot = '0; ca4l_awvalid = 0; ca4l_wdata = '0; ca4l_wstrb = '0;
    ca4l_wvalid = 0; ca4l_bready = 0; ca4l_araddr = '0; ca4l_arprot = '0; ca4l_arvalid = 0;
    ca4l_rready = 0; status_in = '0; event_in = '0;
    model_reset();

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge fclk);
    check("rst_bvalid", ca4l_bvalid, 0);
    check("rst_rvalid", ca4l_rvalid, 0);
    check("rst_irq", irq, 0);
    check("rst_ready", {ca4l_awready, ca4l_wready, ca4l_arready}, 0);
    check("rst_ctrl", ctrl_out, 0);
    rst = 1'b0;
    #1 check("ready_before_edge", {ca4l_awready, ca4l_wready, ca4l_arready}, 0);
    @(negedge fclk);
    check("ready_after_edge", {ca4l_awready, ca4l_wready, ca4l_arready}, 3'b111);
    for (int i = 0; i < 8; i++) if (i != 6) axi_read(i, 0, 0);

    // AW first, W three cycles later, low two bytes only
    axi_write(1, 32'hA5A5_1234, 4'b0011, 0, 3, 0, '0);
    check("ctrl_low_bytes", ctrl_out, 32'h0000_1234);

    // ID read with rready held off
    axi_read(0, 0, 5);

    // read captured on the commit edge of a write to the same register sees the old value
    fork
      axi_write(1, 32'h0BAD_F00D, 4'hF, 0, 0, 3, '0);
      axi_read(1, 1, 0);
    join
    axi_read(1, 0, 0);
    check("ctrl_after_overlap", ctrl_out, 32'h0BAD_F00D);

    // status sampling
    status_in = $urandom;
    tick(); tick();
    m_status = status_in;
    axi_read(2, 0, 1);

    // random traffic over the whole map
    for (int n = 0; n < 40; n++) begin
      int idx;
      idx = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        axi_write(idx, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2), '0);
        check("ctrl_out", ctrl_out, m_ctrl);
      end else begin
        axi_read(idx, $urandom_range(0, 2), $urandom_range(0, 3));
      end
    end
    check("irq_no_events", irq, 0);

    // invalid offset and read-only CYCLES
    axi_write(7, $urandom, 4'hF, 1, 0, 1, '0);
    for (int i = 1; i < 8; i++) if (i != 6) axi_read(i, 0, 0);
    axi_write(6, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, '0);
    axi_read(6, 0, 0);
    axi_write(0, 32'h1234_5678, 4'hF, 0, 1, 0, '0);
    axi_read(0, 0, 0);

    // interrupt: enable bit 2, pulse event 2
    axi_write(4, 32'h0000_0004, 4'hF, 0, 0, 0, '0);
    event_in[2] = 1'b1;
    tick();
    event_in = '0;
    m_pend[2] = 1'b1;
    check("irq_1_cycle", irq, 0);
    tick();
    check("irq_2_cycles", irq, 1);
    // W1C coinciding with a fresh event leaves the bit set
    axi_write(3, 32'h0000_0004, 4'hF, 0, 0, 1, 8'h04);
    check("irq_kept", irq, 1);
    tick();
    check("irq_kept_later", irq, 1);
    axi_read(3, 0, 0);
    // plain W1C clears it and irq follows
    axi_write(3, 32'h0000_0004, 4'hF, 0, 0, 0, '0);
    tick();
    check("irq_cleared", irq, 0);
    axi_read(3, 0, 0);
    // a masked event pends but does not interrupt
    event_in[5] = 1'b1;
    tick();
    event_in = '0;
    m_pend[5] = 1'b1;
    tick(); tick();
    check("irq_masked", irq, 0);
    axi_read(3, 0, 0);

    // reset while a write response is pending
    axi_write(1, 32'hCAFE_F00D, 4'hF, 0, 0, 0, '0);
    check("ctrl_before_abort", ctrl_out, 32'hCAFE_F00D);
    ca4l_awaddr = 32'h0000_0004; ca4l_wdata = 32'hDEAD_BEEF; ca4l_wstrb = 4'hF;
    ca4l_awvalid = 1'b1; ca4l_wvalid = 1'b1;
    tick();
    ca4l_awvalid = 1'b0; ca4l_wvalid = 1'b0;
    check("bvalid_pending", ca4l_bvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_bvalid", ca4l_bvalid, 0);
    check("abort_ctrl", ctrl_out, 0);
    check("abort_irq", irq, 0);
    check("abort_ready", {ca4l_awready, ca4l_wready, ca4l_arready}, 0);
    repeat (2) @(negedge fclk);
    rst = 1'b0;
    model_reset();
    m_status = status_in;
    tick();
    check("abort_no_resp", ca4l_bvalid, 0);
    axi_write(5, 32'h1357_9BDF, 4'b1010, 2, 0, 1, '0);
    axi_read(5, 0, 2);
    axi_read(1, 0, 0);
    check("ctrl_after_abort", ctrl_out, 0);
    axi_read(6, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
